// File: rtl/gol_pkg.sv
// gol_pkg: state encoding, Conway B3/S23 rule masks and a popcount helper
// shared by the Game of Life grid engine and its row evaluator.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit n set: a cell with n live neighbours is born / survives.
    localparam logic [8:0] BIRTH_MASK   = 9'b000001000;
    localparam logic [8:0] SURVIVE_MASK = 9'b000001100;

    // Widest row the popcount helper accepts; callers zero-extend narrower rows.
    localparam int POP_W = 64;

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_W; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gol_row_next.sv
// gol_row_next: combinational next-generation evaluator for one grid row,
// given the old rows above, at and below it.
module gol_row_next
    import gol_pkg::*;
#(
    parameter int COLS = 8,
    parameter bit WRAP = 1'b1
) (
    input  logic [COLS-1:0] above_i,
    input  logic [COLS-1:0] cur_i,
    input  logic [COLS-1:0] below_i,
    output logic [COLS-1:0] next_o
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int L     = (c == 0) ? COLS - 1 : c - 1;
        localparam int R     = (c == COLS - 1) ? 0 : c + 1;
        localparam bit HAS_L = WRAP || (c != 0);
        localparam bit HAS_R = WRAP || (c != COLS - 1);

        logic [2:0] leftBits;
        logic [2:0] rightBits;
        logic [3:0] n;

        // Edge columns see dead neighbours unless the grid is toroidal.
        assign leftBits  = HAS_L ? {above_i[L], cur_i[L], below_i[L]} : 3'b000;
        assign rightBits = HAS_R ? {above_i[R], cur_i[R], below_i[R]} : 3'b000;

        assign n = 4'(leftBits[0]) + 4'(leftBits[1]) + 4'(leftBits[2])
                 + 4'(rightBits[0]) + 4'(rightBits[1]) + 4'(rightBits[2])
                 + 4'(above_i[c]) + 4'(below_i[c]);

        assign next_o[c] = BIRTH_MASK[n] | (cur_i[c] & SURVIVE_MASK[n]);
    end

endmodule

// File: rtl/gol_grid_engine.sv
// gol_grid_engine: register-held ROWS x COLS Game of Life grid, one generation per
// start at one row per clock. `define GOL_STABLE_DETECT_EN adds still-life detection.
module gol_grid_engine
    import gol_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter bit WRAP  = 1'b1,
    parameter int GEN_W = 16,
    localparam int ROW_W   = $clog2(ROWS),
    localparam int ALIVE_W = $clog2(ROWS * COLS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [ROW_W-1:0]   load_row,
    input  logic [COLS-1:0]    load_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [ROW_W-1:0]   rd_row,
    output logic [COLS-1:0]    rd_data,
    output logic [GEN_W-1:0]   gen_count,
    output logic [ALIVE_W-1:0] alive_count,
    output logic               stable
);

    state_t state_q, state_d;

    logic [COLS-1:0]    grid_q [ROWS];
    logic [COLS-1:0]    prevBuf_q;
    logic [COLS-1:0]    row0Buf_q;
    logic [COLS-1:0]    rdData_q;
    logic [ROW_W-1:0]   rowIdx_q;
    logic [ALIVE_W-1:0] sum_q;
    logic [ALIVE_W-1:0] aliveCount_q;
    logic [GEN_W-1:0]   genCount_q;
    logic               recount_q;

    logic               running;
    logic               startGo;
    logic               loadHit;
    logic               lastRow;
    logic [COLS-1:0]    curRow;
    logic [COLS-1:0]    aboveRow;
    logic [COLS-1:0]    belowRow;
    logic [COLS-1:0]    newRow;
    logic [ALIVE_W-1:0] sumNext;
    logic [ALIVE_W-1:0] gridPop;

    assign running = (state_q == RUN);
    assign startGo = (state_q == IDLE) && start && !load_valid;
    assign loadHit = (state_q == IDLE) && load_valid && (int'(load_row) < ROWS);
    assign lastRow = (rowIdx_q == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (startGo) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (lastRow) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // prevBuf holds the old version of row r-1 because grid[r-1] is already overwritten.
    always_comb begin
        curRow   = grid_q[rowIdx_q];
        aboveRow = prevBuf_q;
        belowRow = grid_q[rowIdx_q + 1'b1];
        if (!WRAP && rowIdx_q == '0) aboveRow = '0;
        if (lastRow) belowRow = WRAP ? row0Buf_q : '0;
    end

    gol_row_next #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row_next (
        .above_i (aboveRow),
        .cur_i   (curRow),
        .below_i (belowRow),
        .next_o  (newRow)
    );

    assign sumNext = sum_q + ALIVE_W'(popcount(POP_W'(newRow)));

    always_comb begin
        gridPop = '0;
        for (int r = 0; r < ROWS; r++) begin
            gridPop = gridPop + ALIVE_W'(popcount(POP_W'(grid_q[r])));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
            prevBuf_q <= '0;
            row0Buf_q <= '0;
            rowIdx_q  <= '0;
            sum_q     <= '0;
            recount_q <= 1'b0;
        end else begin
            recount_q <= loadHit;
            if (loadHit) begin
                grid_q[load_row] <= load_data;
            end else if (running) begin
                grid_q[rowIdx_q] <= newRow;
            end
            if (startGo) begin
                row0Buf_q <= grid_q[0];
                prevBuf_q <= grid_q[ROWS-1];
                rowIdx_q  <= '0;
                sum_q     <= '0;
            end else if (running) begin
                prevBuf_q <= curRow;
                rowIdx_q  <= rowIdx_q + 1'b1;
                sum_q     <= sumNext;
            end
        end
    end

    // Counters settle on the RUN->DONE edge so they are valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            genCount_q   <= '0;
            aliveCount_q <= '0;
        end else if (running && lastRow) begin
            genCount_q   <= genCount_q + 1'b1;
            aliveCount_q <= sumNext;
        end else if (recount_q) begin
            aliveCount_q <= gridPop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= (int'(rd_row) < ROWS) ? grid_q[rd_row] : '0;
        end
    end

    assign rd_data     = rdData_q;
    assign gen_count   = genCount_q;
    assign alive_count = aliveCount_q;

`ifdef GOL_STABLE_DETECT_EN
    logic eqFlag_q;
    logic stable_q;
    logic eqNext;

    // Sticky equality starts true each generation and drops on the first changed row.
    assign eqNext = eqFlag_q && (newRow == curRow);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eqFlag_q <= 1'b0;
            stable_q <= 1'b0;
        end else if (loadHit) begin
            stable_q <= 1'b0;
        end else if (startGo) begin
            eqFlag_q <= 1'b1;
        end else if (running) begin
            eqFlag_q <= eqNext;
            if (lastRow) stable_q <= eqNext;
        end
    end

    assign stable = stable_q;
`else
    assign stable = 1'b0;
`endif

endmodule

// File: tb/tb_gol_grid_engine.sv
// Scoreboard bench for gol_grid_engine: a toroidal and a dead-border 8x8 instance
// driven with directed patterns whose successors were worked out by hand.
`timescale 1ns/1ps
module tb_gol_grid_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
`ifdef GOL_STABLE_DETECT_EN
    localparam bit STABLE_EN = 1'b1;
`else
    localparam bit STABLE_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] gen;
        logic [6:0]  alive;
        logic        stable;
        int          doneCyc;
    } exp_t;

    logic        clk;
    logic        rst        [2];
    logic        loadValid  [2];
    logic [2:0]  loadRow    [2];
    logic [7:0]  loadData   [2];
    logic        start      [2];
    logic        busy       [2];
    logic        done       [2];
    logic [2:0]  rdRow      [2];
    logic [7:0]  rdData     [2];
    logic [15:0] genCount   [2];
    logic [6:0]  aliveCount [2];
    logic        stable     [2];

    exp_t sbQ0[$];
    exp_t sbQ1[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   cyc     = 0;
    int   expGen  [2];

    gol_grid_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b1), .GEN_W(16)) dutWrap (
        .clk(clk), .rst(rst[0]), .load_valid(loadValid[0]), .load_row(loadRow[0]),
        .load_data(loadData[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .rd_row(rdRow[0]), .rd_data(rdData[0]), .gen_count(genCount[0]),
        .alive_count(aliveCount[0]), .stable(stable[0])
    );

    gol_grid_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b0), .GEN_W(16)) dutDead (
        .clk(clk), .rst(rst[1]), .load_valid(loadValid[1]), .load_row(loadRow[1]),
        .load_data(loadData[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .rd_row(rdRow[1]), .rd_data(rdData[1]), .gen_count(genCount[1]),
        .alive_count(aliveCount[1]), .stable(stable[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor side of the scoreboard: every done pulse consumes one expected result.
    task automatic scoreDone(input int d);
        exp_t e;
        if ((d == 0 && sbQ0.size() == 0) || (d == 1 && sbQ1.size() == 0)) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL unexpectedDone%0d: done=1 at cycle %0d, expected no done", d, cyc);
            return;
        end
        if (d == 0) e = sbQ0.pop_front();
        else        e = sbQ1.pop_front();
        checkOutput($sformatf("genCount%0d", d), 64'(genCount[d]), 64'(e.gen));
        checkOutput($sformatf("aliveCount%0d", d), 64'(aliveCount[d]), 64'(e.alive));
        checkOutput($sformatf("stable%0d", d), 64'(stable[d]), 64'(e.stable));
        checkOutput($sformatf("doneCycle%0d", d), 64'(cyc), 64'(e.doneCyc));
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done[d] === 1'b1) scoreDone(d);
        end
    end

    // Loads all eight rows; row r of the image sits in img[8r+7:8r].
    task automatic applyStimulus(input int d, input logic [63:0] img, input string name);
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            loadValid[d] = 1'b1;
            loadRow[d]   = 3'(r);
            loadData[d]  = img[r*8 +: 8];
        end
        @(negedge clk);
        loadValid[d] = 1'b0;
        @(negedge clk);
        checkOutput({name, "_alive"}, 64'(aliveCount[d]), 64'($countones(img)));
        checkOutput({name, "_stable"}, 64'(stable[d]), 64'(0));
    endtask

    task automatic checkGrid(input int d, input logic [63:0] img, input string name);
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            rdRow[d] = 3'(r);
            @(negedge clk);
            checkOutput($sformatf("%s_row%0d", name, r), 64'(rdData[d]), 64'(img[r*8 +: 8]));
        end
    endtask

    task automatic runGen(input int d, input int expAlive, input bit expStable, input bit disturb);
        exp_t e;
        bit   seen;
        @(negedge clk);
        expGen[d]  = expGen[d] + 1;
        e.gen      = 16'(expGen[d]);
        e.alive    = 7'(expAlive);
        e.stable   = expStable;
        e.doneCyc  = cyc + ROWS + 1;
        if (d == 0) sbQ0.push_back(e);
        else        sbQ1.push_back(e);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        checkOutput($sformatf("busyAfterStart%0d", d), 64'(busy[d]), 64'(1));
        if (disturb) begin
            start[d]     = 1'b1;
            loadValid[d] = 1'b1;
            loadRow[d]   = 3'd0;
            loadData[d]  = 8'hFF;
            @(negedge clk);
            start[d]     = 1'b0;
            loadValid[d] = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done[d] === 1'b1) begin
                seen = 1'b1;
                checkOutput($sformatf("busyAtDone%0d", d), 64'(busy[d]), 64'(0));
            end
        end
        if (!seen) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL doneTimeout%0d: done=0 after 20 cycles, expected done", d);
        end
    endtask

    function automatic int deadGliderAlive(input int j);
        if (j <= 20) return 5;
        if (j == 21) return 4;
        if (j == 22) return 3;
        return 4;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; loadValid[d] = 1'b0; loadRow[d] = '0; loadData[d] = '0;
            start[d] = 1'b0; rdRow[d] = '0; expGen[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rstBusy%0d", d), 64'(busy[d]), 64'(0));
            checkOutput($sformatf("rstDone%0d", d), 64'(done[d]), 64'(0));
            checkOutput($sformatf("rstGen%0d", d), 64'(genCount[d]), 64'(0));
            checkOutput($sformatf("rstAlive%0d", d), 64'(aliveCount[d]), 64'(0));
            checkOutput($sformatf("rstStable%0d", d), 64'(stable[d]), 64'(0));
            checkOutput($sformatf("rstRdData%0d", d), 64'(rdData[d]), 64'(0));
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        $display("[TB] toroidal instance");
        applyStimulus(0, 64'h00000000_000E0000, "blinkerLoad");
        checkGrid(0, 64'h00000000_000E0000, "blinkerLoad");
        runGen(0, 3, 1'b0, 1'b0);
        checkGrid(0, 64'h00000000_04040400, "blinkerGen");
        runGen(0, 3, 1'b0, 1'b1);
        checkGrid(0, 64'h00000000_000E0000, "blinkerIgnored");
        applyStimulus(0, 64'h00000000_00060600, "blockLoad");
        runGen(0, 4, STABLE_EN, 1'b0);
        checkGrid(0, 64'h00000000_00060600, "blockGen");
        applyStimulus(0, 64'h00000000_00000007, "rowWrapLoad");
        runGen(0, 3, 1'b0, 1'b0);
        checkGrid(0, 64'h02000000_00000202, "rowWrapGen");
        applyStimulus(0, 64'h00000001_01010000, "colWrapLoad");
        runGen(0, 3, 1'b0, 1'b0);
        checkGrid(0, 64'h00000000_83000000, "colWrapGen");
        applyStimulus(0, 64'h00000000_00070402, "gliderLoad");
        for (int j = 1; j <= 4; j++) runGen(0, 5, 1'b0, 1'b0);
        checkGrid(0, 64'h00000000_0E080400, "gliderStep");
        for (int j = 5; j <= 32; j++) runGen(0, 5, 1'b0, 1'b0);
        checkGrid(0, 64'h00000000_00070402, "gliderHome");

        $display("[TB] dead-border instance");
        applyStimulus(1, 64'h00000000_00000001, "cornerLoad");
        runGen(1, 0, 1'b0, 1'b0);
        checkGrid(1, 64'h00000000_00000000, "cornerGen");
        applyStimulus(1, 64'h00000000_00000007, "rowEdgeLoad");
        runGen(1, 2, 1'b0, 1'b0);
        checkGrid(1, 64'h00000000_00000202, "rowEdgeGen");
        applyStimulus(1, 64'h00000001_01010000, "colEdgeLoad");
        runGen(1, 2, 1'b0, 1'b0);
        checkGrid(1, 64'h00000000_03000000, "colEdgeGen");
        applyStimulus(1, 64'h00000000_00070402, "deadGliderLoad");
        for (int j = 1; j <= 30; j++) runGen(1, deadGliderAlive(j), STABLE_EN && (j >= 24), 1'b0);
        checkGrid(1, 64'hC0C00000_00000000, "deadGliderBlock");

        $display("[TB] reset during RUN");
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        checkOutput("midRstBusy", 64'(busy[0]), 64'(0));
        checkOutput("midRstDone", 64'(done[0]), 64'(0));
        checkOutput("midRstGen", 64'(genCount[0]), 64'(0));
        checkOutput("midRstAlive", 64'(aliveCount[0]), 64'(0));
        checkOutput("midRstRdData", 64'(rdData[0]), 64'(0));
        rst[0] = 1'b0;
        expGen[0] = 0;
        checkGrid(0, 64'h0, "gridAfterReset");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("noDoneAfterReset", 64'(done[0]), 64'(0));
        end

        checkOutput("scoreboardEmpty0", 64'(sbQ0.size()), 64'(0));
        checkOutput("scoreboardEmpty1", 64'(sbQ1.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/gol_grid_engine.md
# gol_grid_engine

Parametrised Game of Life generation engine. Holds a ROWS×COLS cell grid in registers and computes one Conway B3/S23 generation per start request, row-serially at one row per clock. It sits between the button/seed logic and the LED frame streamer in the top level. Relative to the fixed-size engine, it adds selectable toroidal or dead-border edges, a generation counter, a population count and a registered row read port.

## Interface
- ROWS, default 8: grid rows; ≥3.
- COLS, default 8: grid columns; ≥3.
- WRAP, default 1: 1 = toroidal edges; 0 = cells outside the grid are dead.
- GEN_W, default 16: generation counter width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- load_valid  in  1  write one grid row; accepted only in IDLE.
- load_row  in  $clog2(ROWS)  row index for the load.
- load_data  in  COLS  row contents; bit c = column c, 1 = alive.
- start  in  1  one-cycle request to compute the next generation.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a generation completes.
- rd_row  in  $clog2(ROWS)  read row index.
- rd_data  out  COLS  grid[rd_row], registered.
- gen_count  out  GEN_W  number of completed generations.
- alive_count  out  $clog2(ROWS*COLS+1)  population after the last load or generation.
- stable  out  1  the last generation equalled its predecessor (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start (without load_valid):
  - Copy grid row 0 into row0_buf and row ROWS-1 into prev_buf.
  - Set r=0 and go to RUN.
- RUN, each cycle:
  - Compute next row r from old rows r-1, r, r+1.
  - Above row: prev_buf. Below row: grid[r+1], or row0_buf when r=ROWS-1.
  - With WRAP=0: the above row is zero at r=0, the below row is zero at r=ROWS-1, and column neighbours outside 0..COLS-1 are zero.
  - With WRAP=1: column indices wrap modulo COLS.
  - Write the new row to grid[r] and copy old grid[r] into prev_buf.
  - Add the popcount of the new row to a running sum.
  - After r=ROWS-1, go to DONE.
- DONE, one cycle:
  - Pulse done.
  - gen_count += 1, wrapping modulo 2^GEN_W.
  - alive_count ← running sum.
  - Return to IDLE.
- Cell rule: n = live neighbour count (0..8, 4-bit). Next = (n==3) | (alive & n==2).
- Load: in IDLE, load_valid writes grid[load_row] ← load_data and recomputes alive_count on the next cycle.
  - load_row ≥ ROWS is ignored.
  - load_valid in RUN or DONE is ignored.
- start and load_valid together in IDLE: the load is written and start is ignored.
- start in RUN or DONE is ignored; it is not queued.
- Read port: rd_data ← grid[rd_row] every cycle, in all states. Reads during RUN return partially updated rows.
- rd_row ≥ ROWS returns 0.

## Timing
- Reset values:
  - Grid, prev_buf and row0_buf all zero.
  - State IDLE; busy=0, done=0, rd_data=0, gen_count=0, alive_count=0, stable=0.
- start sampled at edge T: busy=1 from T+1 to T+ROWS; done=1 at T+ROWS+1; busy=0 in that cycle.
- Start-to-done latency: ROWS+1 cycles. The next start is accepted at T+ROWS+2.
- gen_count, alive_count and stable update in the same cycle done is high.
- Load at edge T: grid visible on rd_data at T+2; alive_count valid at T+2.
- Reset mid-RUN: everything returns to reset values immediately. No done pulse; the partial generation is discarded.

## Configuration
- GOL_STABLE_DETECT_EN defined:
  - During RUN, each new row is compared with the old row; any difference clears a sticky equal flag.
  - In DONE: stable ← equal flag.
  - A load clears stable.
- Not defined: comparison logic is absent and stable is tied to 0.

## Structure
- Package gol_pkg holds:
  - State enum state_t {IDLE, RUN, DONE}.
  - Rule constants BIRTH_MASK=9'b000001000 and SURVIVE_MASK=9'b000001100, indexed by n.
  - Function popcount.
- Sub-module gol_row_next is purely combinational: inputs above, cur and below rows (COLS each) plus WRAP; output next row. It applies the rule constants.

## Test plan
- 5×5, WRAP=1, horizontal blinker rows 2 = 5'b01110, start → done 6 cycles after start; row 1,2,3 = 5'b00100; alive_count=3; gen_count=1; stable=0.
- 4×4 block at rows 1–2 = 4'b0110, start → grid unchanged, alive_count=4, stable=1 with GOL_STABLE_DETECT_EN; stable=0 without it.
- 8×8 glider, WRAP=1, 32 generations → glider returns to its start position with gen_count=32, alive_count=5. With WRAP=0, the same glider leaves a 2×2 block in the corner, and alive_count=4 once stable.
- Single corner cell (row 0, column 0), WRAP=0 → after one generation alive_count=0.
- start pulsed again at busy=1, plus load_valid during RUN → ignored; the result equals the single-start result; gen_count increments by exactly 1.
- rst asserted at RUN cycle 3 → busy=0, gen_count=0, all rd_data=0 next cycle; no done pulse.
